hmm_emission_scorer: RTL and testbench

- Front-end stage feeding the 3-HMM Viterbi decoder.
- Accepts one feature vector per frame (DIM signed samples) and computes a diagonal-Gaussian log-likelihood score per state for each of the three HMMs.
- Presents the scores to the decoder using its write/start load protocol, triggers decoding, and captures the decoder's per-frame decision.

---
 rtl/hmm_emission_scorer_if.sv | 34 +++
 rtl/hmm_emission_scorer.sv | 215 +++++++++++++++++++++
 tb/tb_hmm_emission_scorer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hmm_emission_scorer_if.sv
// ---------------------------------------------------------------------------
// hmm_emission_scorer_if
//   Bus bundle between the emission scorer, its feature source and the
//   downstream 3-HMM Viterbi decoder.
//   Feature stream : feat_valid, feat_data (signed, dim 0 first), feat_ready
//   Decoder load   : vit_start, vit_write, vit_x1/x2/x3 (signed scores)
//   Decoder status : vit_busy, vit_dv, vit_result
//   Modports: slave = the scorer, master = the surrounding environment.
// ---------------------------------------------------------------------------
interface hmm_emission_scorer_if #(
  parameter int DW = 16
);
  logic                 feat_valid;
  logic signed [DW-1:0] feat_data;
  logic                 feat_ready;
  logic                 vit_start;
  logic                 vit_write;
  logic signed [31:0]   vit_x1;
  logic signed [31:0]   vit_x2;
  logic signed [31:0]   vit_x3;
  logic                 vit_busy;
  logic                 vit_dv;
  logic                 vit_result;

  modport slave (
    input  feat_valid, feat_data, vit_busy, vit_dv, vit_result,
    output feat_ready, vit_start, vit_write, vit_x1, vit_x2, vit_x3
  );

  modport master (
    output feat_valid, feat_data, vit_busy, vit_dv, vit_result,
    input  feat_ready, vit_start, vit_write, vit_x1, vit_x2, vit_x3
  );
endinterface

// File: rtl/hmm_emission_scorer.sv
// ---------------------------------------------------------------------------
// hmm_emission_scorer
//   Computes a diagonal-Gaussian log-likelihood score per state for three
//   HMMs from one feature vector per frame, loads the scores into the
//   Viterbi decoder (write/start protocol) and captures its decision.
//
// Ports
//   clk, reset       : clock, asynchronous active-low reset
//   i_cfg_*          : parameter write port (mean / inv-variance / bias),
//                      honoured only while idle
//   bus (slave)      : feature stream and decoder interface
//   o_frame_valid    : one-cycle pulse when a frame decision is available
//   o_frame_result   : latched decoder result
//   o_frame_cnt      : completed frames, wraps
//
// Build option
//   SCORE_SAT_EN     : when defined, bias - (acc >> SHIFT) is computed at
//                      57 bits and clamped to the signed 32-bit range;
//                      otherwise the low 32 bits are emitted (wrap).
// ---------------------------------------------------------------------------
module hmm_emission_scorer #(
  parameter int STATE = 5,
  parameter int DIM   = 13,
  parameter int DW    = 16,
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_cfg_we,
  input  logic [1:0]           i_cfg_hmm,
  input  logic [1:0]           i_cfg_sel,
  input  logic [7:0]           i_cfg_state,
  input  logic [7:0]           i_cfg_dim,
  input  logic [31:0]          i_cfg_data,
  hmm_emission_scorer_if.slave bus,
  output logic                 o_frame_valid,
  output logic                 o_frame_result,
  output logic [15:0]          o_frame_cnt
);
  localparam int SW  = (STATE > 1) ? $clog2(STATE) : 1;
  localparam int DIW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int SQW = 2*DW + 2;
  localparam int PW  = 2*DW + 18;
  localparam int AW  = 56;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_EMIT, S_TRIG, S_WAIT, S_DONE
  } state_t;

  state_t r_state, w_nextState;

  logic signed [DW-1:0] r_mean [3][STATE][DIM];
  logic [15:0]          r_ivar [3][STATE][DIM];
  logic signed [31:0]   r_bias [3][STATE];
  logic signed [DW-1:0] r_featBuf [DIM];

  logic [SW-1:0]      r_sIdx;
  logic [DIW-1:0]     r_dIdx;
  logic [AW-1:0]      r_acc [3];
  logic signed [31:0] r_x [3];
  logic               r_startHeld;
  logic               r_frameResult;
  logic [15:0]        r_frameCnt;

  logic               w_beat, w_lastDim, w_lastState, w_latchResult;
  logic               w_featReady, w_vitWrite, w_vitStart, w_frameValid;
  logic [AW-1:0]      w_accNext [3];
  logic signed [31:0] w_score [3];

  assign w_beat        = bus.feat_valid && (r_state == S_LOAD);
  assign w_lastDim     = (r_dIdx == DIW'(DIM-1));
  assign w_lastState   = (r_sIdx == SW'(STATE-1));
  // A dv seen together with the first busy in TRIG completes the frame too
  assign w_latchResult = ((r_state == S_TRIG) && bus.vit_busy && bus.vit_dv) ||
                         ((r_state == S_WAIT) && bus.vit_dv);

  // Parameter tables are deliberately not reset; out-of-range indices match
  // no entry and are silently dropped.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && i_cfg_we) begin
      for (int h = 0; h < 3; h++) begin
        for (int s = 0; s < STATE; s++) begin
          if (i_cfg_hmm == 2'(h) && i_cfg_state == 8'(s)) begin
            if (i_cfg_sel == 2'd2) r_bias[h][s] <= i_cfg_data;
            for (int d = 0; d < DIM; d++) begin
              if (i_cfg_dim == 8'(d)) begin
                if (i_cfg_sel == 2'd0) r_mean[h][s][d] <= i_cfg_data[DW-1:0];
                if (i_cfg_sel == 2'd1) r_ivar[h][s][d] <= i_cfg_data[15:0];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) r_featBuf[r_dIdx] <= bus.feat_data;
  end

  // One MAC lane per HMM. The score is formed from the accumulator value
  // that includes the last dimension, so it is registered in the final MAC
  // cycle and is already on vit_x* during EMIT.
  for (genvar h = 0; h < 3; h++) begin : g_hmm
    logic signed [DW:0] w_diff;
    logic [SQW-1:0]     w_sq;
    logic [PW-1:0]      w_prod;
    logic [AW-1:0]      w_shift;

    assign w_diff = {r_featBuf[r_dIdx][DW-1], r_featBuf[r_dIdx]} -
                    {r_mean[h][r_sIdx][r_dIdx][DW-1], r_mean[h][r_sIdx][r_dIdx]};
    assign w_sq   = SQW'(w_diff) * SQW'(w_diff);
    assign w_prod = PW'(w_sq) * PW'(r_ivar[h][r_sIdx][r_dIdx]);
    assign w_accNext[h] = ((r_dIdx == '0) ? '0 : r_acc[h]) + AW'(w_prod);
    assign w_shift = w_accNext[h] >> SHIFT;

`ifdef SCORE_SAT_EN
    localparam logic signed [AW:0] SAT_MAX = {{(AW-30){1'b0}}, {31{1'b1}}};
    localparam logic signed [AW:0] SAT_MIN = {{(AW-30){1'b1}}, {31{1'b0}}};
    logic signed [AW:0] w_wide;

    assign w_wide = {{(AW-31){r_bias[h][r_sIdx][31]}}, r_bias[h][r_sIdx]} -
                    {1'b0, w_shift};
    assign w_score[h] = (w_wide > SAT_MAX) ? 32'sh7FFFFFFF :
                        (w_wide < SAT_MIN) ? 32'sh80000000 : w_wide[31:0];
`else
    assign w_score[h] = 32'(AW'(r_bias[h][r_sIdx]) - w_shift);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_featReady  = 1'b0;
    w_vitWrite   = 1'b0;
    w_vitStart   = r_startHeld;
    w_frameValid = 1'b0;
    case (r_state)
      S_IDLE: if (!bus.vit_busy) w_nextState = S_LOAD;
      S_LOAD: begin
        w_featReady = 1'b1;
        if (w_beat && w_lastDim) w_nextState = S_MAC;
      end
      S_MAC:  if (w_lastDim) w_nextState = S_EMIT;
      S_EMIT: begin
        w_vitWrite  = 1'b1;
        w_vitStart  = 1'b1;
        w_nextState = w_lastState ? S_TRIG : S_MAC;
      end
      S_TRIG: if (bus.vit_busy) w_nextState = bus.vit_dv ? S_DONE : S_WAIT;
      S_WAIT: if (bus.vit_dv) w_nextState = S_DONE;
      S_DONE: begin
        w_vitStart   = 1'b0;
        w_frameValid = 1'b1;
        w_nextState  = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Indices, accumulators, score registers and frame bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sIdx        <= '0;
      r_dIdx        <= '0;
      r_acc         <= '{default: '0};
      r_x           <= '{default: '0};
      r_startHeld   <= 1'b0;
      r_frameResult <= 1'b0;
      r_frameCnt    <= '0;
    end else begin
      if (w_latchResult) r_frameResult <= bus.vit_result;
      case (r_state)
        S_LOAD: begin
          if (w_beat) begin
            r_dIdx <= w_lastDim ? '0 : r_dIdx + DIW'(1);
            r_sIdx <= '0;
          end
        end
        S_MAC: begin
          for (int h = 0; h < 3; h++) r_acc[h] <= w_accNext[h];
          if (w_lastDim) begin
            for (int h = 0; h < 3; h++) r_x[h] <= w_score[h];
            r_dIdx <= '0;
          end else begin
            r_dIdx <= r_dIdx + DIW'(1);
          end
        end
        S_EMIT: begin
          r_startHeld <= 1'b1;
          if (!w_lastState) r_sIdx <= r_sIdx + SW'(1);
        end
        S_DONE: begin
          r_startHeld <= 1'b0;
          r_frameCnt  <= r_frameCnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.feat_ready = w_featReady;
  assign bus.vit_write  = w_vitWrite;
  assign bus.vit_start  = w_vitStart;
  assign bus.vit_x1     = r_x[0];
  assign bus.vit_x2     = r_x[1];
  assign bus.vit_x3     = r_x[2];
  assign o_frame_valid  = w_frameValid;
  assign o_frame_result = r_frameResult;
  assign o_frame_cnt    = r_frameCnt;
endmodule

// File: tb/tb_hmm_emission_scorer.sv
// ---------------------------------------------------------------------------
// tb_hmm_emission_scorer
//   Self-checking bench for hmm_emission_scorer. Expected scores come from a
//   behavioural model of the parameter tables and are queued when a frame is
//   driven; a monitor pops them on every vit_write. A simple decoder model
//   answers the start/busy/dv handshake. Honours SCORE_SAT_EN like the RTL.
// ---------------------------------------------------------------------------
module tb_hmm_emission_scorer;
  localparam int STATE = 5;
  localparam int DIM   = 13;
  localparam int DW    = 16;
  localparam int SHIFT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfgWe;
  logic [1:0]  cfgHmm, cfgSel;
  logic [7:0]  cfgState, cfgDim;
  logic [31:0] cfgData;
  logic        frameValid, frameResult;
  logic [15:0] frameCnt;

  always #5 clk = ~clk;

  hmm_emission_scorer_if #(.DW(DW)) bus ();

  hmm_emission_scorer #(.STATE(STATE), .DIM(DIM), .DW(DW), .SHIFT(SHIFT)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_cfg_we       (cfgWe),
    .i_cfg_hmm      (cfgHmm),
    .i_cfg_sel      (cfgSel),
    .i_cfg_state    (cfgState),
    .i_cfg_dim      (cfgDim),
    .i_cfg_data     (cfgData),
    .bus            (bus),
    .o_frame_valid  (frameValid),
    .o_frame_result (frameResult),
    .o_frame_cnt    (frameCnt)
  );

  typedef struct {
    longint x1;
    longint x2;
    longint x3;
  } emit_t;

  emit_t  emitQ[$];
  bit     frameQ[$];
  int     assertCount = 0;
  int     failCount = 0;
  int     emitsSeen = 0;
  int     framesSeen = 0;
  int     modelCnt = 0;
  longint lastExp3 = 0;

  int mMean [3][STATE][DIM];
  int mIvar [3][STATE][DIM];
  int mBias [3][STATE];
  int featVec [DIM];

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input int h, input int sel, input int st, input int dm,
                          input logic [31:0] data, input bit accept);
    cfgWe    = 1'b1;
    cfgHmm   = 2'(h);
    cfgSel   = 2'(sel);
    cfgState = 8'(st);
    cfgDim   = 8'(dm);
    cfgData  = data;
    tick();
    cfgWe = 1'b0;
    if (accept) begin
      case (sel)
        0: mMean[h][st][dm] = int'($signed(data[15:0]));
        1: mIvar[h][st][dm] = int'(data[15:0]);
        2: mBias[h][st]     = int'($signed(data));
        default: ;
      endcase
    end
  endtask

  function automatic longint scoreModel(input int h, input int s);
    longint acc, diff, v;
    acc = 0;
    for (int d = 0; d < DIM; d++) begin
      diff = longint'(featVec[d]) - longint'(mMean[h][s][d]);
      acc += diff * diff * longint'(mIvar[h][s][d]);
    end
    v = longint'(mBias[h][s]) - (acc >>> SHIFT);
`ifdef SCORE_SAT_EN
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    else if (v < -64'sd2147483648) v = -64'sd2147483648;
`else
    v = longint'($signed(v[31:0]));
`endif
    return v;
  endfunction

  // Queue the expected scores, then stream the frame (optionally with gaps)
  task automatic applyStimulus(input bit gaps);
    emit_t e;
    int    wc;
    bit    timedOut = 1'b0;
    for (int s = 0; s < STATE; s++) begin
      e.x1 = scoreModel(0, s);
      e.x2 = scoreModel(1, s);
      e.x3 = scoreModel(2, s);
      emitQ.push_back(e);
    end
    bus.vit_busy = 1'b0;
    for (int d = 0; d < DIM; d++) begin
      bus.feat_valid = 1'b1;
      bus.feat_data  = DW'(featVec[d]);
      wc = 0;
      while (!bus.feat_ready && wc < 100) begin
        tick();
        wc++;
      end
      if (wc >= 100) timedOut = 1'b1;
      tick();
      bus.feat_valid = 1'b0;
      if (gaps) begin
        bus.feat_data = 16'h5A5A;
        tick();
      end
    end
    checkOutput("loadTimeout", timedOut, 0);
  endtask

  // Decoder model: after the last score, go busy, answer with dv, keep busy
  task automatic runDecoder(input bit result, input int latency, input bit sameCycle);
    int wc = 0;
    int fs = framesSeen;
    while (emitsSeen < STATE && wc < 500) begin
      tick();
      wc++;
    end
    checkOutput("trigReached", wc < 500, 1);
    checkOutput("startHeld", bus.vit_start, 1);
    checkOutput("writeLowInTrig", bus.vit_write, 0);
    checkOutput("x3Hold", longint'($signed(bus.vit_x3)), lastExp3);
    frameQ.push_back(result);
    bus.vit_busy   = 1'b1;
    bus.vit_result = result;
    bus.vit_dv     = sameCycle;
    if (!sameCycle) begin
      repeat (latency) tick();
      bus.vit_dv = 1'b1;
    end
    tick();
    bus.vit_dv = 1'b0;
    wc = 0;
    while (framesSeen == fs && wc < 50) begin
      tick();
      wc++;
    end
    checkOutput("frameDone", framesSeen > fs, 1);
    modelCnt = (modelCnt + 1) & 16'hFFFF;
    checkOutput("frame_cnt", frameCnt, modelCnt);
    checkOutput("startDropped", bus.vit_start, 0);
  endtask

  // Monitor: compare emitted scores and frame decisions against the queues
  initial begin : monitor
    emit_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.vit_write) begin
        checkOutput("emitExpected", emitQ.size() > 0, 1);
        if (emitQ.size() > 0) begin
          e = emitQ.pop_front();
          checkOutput("vit_x1", longint'($signed(bus.vit_x1)), e.x1);
          checkOutput("vit_x2", longint'($signed(bus.vit_x2)), e.x2);
          checkOutput("vit_x3", longint'($signed(bus.vit_x3)), e.x3);
          lastExp3 = e.x3;
        end
        emitsSeen++;
      end
      if (reset && frameValid) begin
        checkOutput("writesPerFrame", emitsSeen, STATE);
        checkOutput("frameExpected", frameQ.size() > 0, 1);
        if (frameQ.size() > 0) checkOutput("frame_result", frameResult, frameQ.pop_front());
        emitsSeen = 0;
        framesSeen++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit readySeen;
    int wc;
    reset          = 1'b0;
    cfgWe          = 1'b0;
    cfgHmm         = '0;
    cfgSel         = '0;
    cfgState       = '0;
    cfgDim         = '0;
    cfgData        = '0;
    bus.feat_valid = 1'b0;
    bus.feat_data  = '0;
    bus.vit_busy   = 1'b1;
    bus.vit_dv     = 1'b0;
    bus.vit_result = 1'b0;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rstStart", bus.vit_start, 0);
    checkOutput("rstWrite", bus.vit_write, 0);
    checkOutput("rstReady", bus.feat_ready, 0);
    checkOutput("rstFrameValid", frameValid, 0);
    checkOutput("rstFrameCnt", frameCnt, 0);
    checkOutput("rstX1", longint'($signed(bus.vit_x1)), 0);
    reset = 1'b1;
    tick();
    checkOutput("idleBusyNoReady", bus.feat_ready, 0);

    $display("[TB] baseline: means 0, ivar 1, bias 0, features 16");
    for (int h = 0; h < 3; h++)
      for (int s = 0; s < STATE; s++) begin
        cfgWrite(h, 2, s, 0, 32'd0, 1);
        for (int d = 0; d < DIM; d++) begin
          cfgWrite(h, 0, s, d, 32'd0, 1);
          cfgWrite(h, 1, s, d, 32'd1, 1);
        end
      end
    for (int d = 0; d < DIM; d++) featVec[d] = 16;
    applyStimulus(1'b0);
    runDecoder(1'b0, 4, 1'b0);

    $display("[TB] bias +1000 on first HMM, decoder answers 1");
    for (int s = 0; s < STATE; s++) cfgWrite(0, 2, s, 0, 32'd1000, 1);
    applyStimulus(1'b0);
    runDecoder(1'b1, 2, 1'b0);

    $display("[TB] extreme distance, dv together with first busy");
    for (int s = 0; s < STATE; s++) begin
      cfgWrite(0, 2, s, 0, 32'hFFFF_FF9C, 1);
      for (int d = 0; d < DIM; d++) begin
        cfgWrite(0, 0, s, d, 32'hFFFF_8000, 1);
        cfgWrite(0, 1, s, d, 32'd65535, 1);
      end
    end
    for (int d = 0; d < DIM; d++) featVec[d] = 32767;
    applyStimulus(1'b0);
    runDecoder(1'b0, 0, 1'b1);

    $display("[TB] per-dim means, busy stall, feature gaps");
    for (int h = 1; h < 3; h++)
      for (int s = 0; s < STATE; s++)
        for (int d = 0; d < DIM; d++) begin
          cfgWrite(h, 0, s, d, 32'(d*500 - 3000 + s*37 + h*11), 1);
          cfgWrite(h, 1, s, d, 32'(d + 1 + s), 1);
        end
    for (int d = 0; d < DIM; d++) featVec[d] = d*311 - 1700;
    readySeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.feat_valid = i[0];
      bus.feat_data  = 16'h7FFF;
      tick();
      readySeen |= bus.feat_ready;
    end
    bus.feat_valid = 1'b0;
    checkOutput("readyWhileBusy", readySeen, 0);
    applyStimulus(1'b1);
    runDecoder(1'b1, 6, 1'b0);

    $display("[TB] config write during MAC is ignored");
    for (int d = 0; d < DIM; d++) featVec[d] = 200 - d*45;
    applyStimulus(1'b0);
    tick();
    tick();
    cfgWrite(2, 2, 1, 0, 32'd77777, 0);
    runDecoder(1'b0, 3, 1'b0);
    applyStimulus(1'b0);
    runDecoder(1'b1, 1, 1'b0);

    $display("[TB] reset during MAC of state 2");
    for (int d = 0; d < DIM; d++) featVec[d] = d*97 - 600;
    applyStimulus(1'b0);
    wc = 0;
    while (emitsSeen < 2 && wc < 300) begin
      tick();
      wc++;
    end
    checkOutput("reachState2", wc < 300, 1);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    checkOutput("midRstStart", bus.vit_start, 0);
    checkOutput("midRstWrite", bus.vit_write, 0);
    checkOutput("midRstX1", longint'($signed(bus.vit_x1)), 0);
    checkOutput("midRstX2", longint'($signed(bus.vit_x2)), 0);
    checkOutput("midRstX3", longint'($signed(bus.vit_x3)), 0);
    checkOutput("midRstFrameCnt", frameCnt, 0);
    checkOutput("midRstFrameValid", frameValid, 0);
    emitQ.delete();
    emitsSeen = 0;
    modelCnt  = 0;
    lastExp3  = 0;
    tick();
    reset = 1'b1;
    for (int d = 0; d < DIM; d++) featVec[d] = 1000 - d*123;
    applyStimulus(1'b0);
    runDecoder(1'b1, 2, 1'b0);

    checkOutput("emitQueueDrained", emitQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
